// File: rtl/synchronizer.sv
// Multi-flop synchronizer for bringing an asynchronous level into the
// clock domain. The output is the last flop of the chain.
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic data,
  output logic synced
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], data};
    end
  end

  assign synced = chain[STAGES-1];

endmodule

// File: rtl/clock_frequency_meter.sv
// Clock frequency meter: samples an asynchronous monitored clock as data,
// counts its rising edges over a fixed window of reference cycles and
// reports the count together with stopped / too-slow / too-fast flags.
module clock_frequency_meter #(
  parameter  int STAGES        = 2,
  parameter  int WINDOW_CYCLES = 1024,
  localparam int COUNT_WIDTH   = $clog2(WINDOW_CYCLES / 2 + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   monitored_clock,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] lower_threshold,
  input  logic [COUNT_WIDTH-1:0] upper_threshold,
  output logic [COUNT_WIDTH-1:0] measurement,
  output logic                   measurement_valid,
  output logic                   clock_stopped,
  output logic                   frequency_low,
  output logic                   frequency_high
);

  localparam int                  WINDOW_WIDTH = $clog2(WINDOW_CYCLES);
  localparam logic [WINDOW_WIDTH-1:0] WINDOW_LAST = WINDOW_WIDTH'(WINDOW_CYCLES - 1);

  logic                    synced_level;
  logic                    previous_level;
  logic                    armed;
  logic                    edge_pulse;
  logic                    window_close;
  logic [WINDOW_WIDTH-1:0] window_count;
  logic [COUNT_WIDTH-1:0]  edge_count;
  logic [COUNT_WIDTH-1:0]  count_next;

  synchronizer #(
    .STAGES (STAGES)
  ) monitored_sync (
    .clock  (clock),
    .reset  (reset),
    .data   (monitored_clock),
    .synced (synced_level)
  );

  // Track last cycle's level; armed stays low for the first cycle after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      previous_level <= 1'b0;
      armed          <= 1'b0;
    end else begin
      previous_level <= synced_level;
      armed          <= 1'b1;
    end
  end

  // Edge detect, window close and saturating next edge count.
  always_comb begin
    edge_pulse   = enable & armed & synced_level & ~previous_level;
    window_close = enable && (window_count == WINDOW_LAST);
    count_next   = edge_count;
    if (edge_pulse && (edge_count != '1)) begin
      count_next = edge_count + 1'b1;
    end
  end

  // Window and edge counters; both clear while disabled and at window close.
  always_ff @(posedge clock) begin
    if (reset) begin
      window_count <= '0;
      edge_count   <= '0;
    end else if (!enable || window_close) begin
      window_count <= '0;
      edge_count   <= '0;
    end else begin
      window_count <= window_count + 1'b1;
      edge_count   <= count_next;
    end
  end

  // Publish the closing window's count (including a closing-cycle edge) and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      measurement       <= '0;
      measurement_valid <= 1'b0;
      clock_stopped     <= 1'b0;
      frequency_low     <= 1'b0;
      frequency_high    <= 1'b0;
    end else begin
      measurement_valid <= 1'b0;
      if (window_close) begin
        measurement       <= count_next;
        measurement_valid <= 1'b1;
        clock_stopped     <= (count_next == '0);
        frequency_low     <= (count_next < lower_threshold);
        frequency_high    <= (count_next > upper_threshold);
      end
    end
  end

endmodule

// File: doc/clock_frequency_meter.md
Name: clock_frequency_meter

Overview:
- Measures the frequency of an asynchronous monitored clock in units of reference-clock cycles, e.g. the output of a glitch-free clock multiplexer or a PLL output.
- Flags stopped, too-slow and too-fast conditions so system control can drive a clock-mux select for failover.
- Samples the monitored clock as data through a synchronizer and counts its rising edges over a fixed window of reference cycles.
- Requirement: the reference clock frequency must be at least 2.5x the monitored clock frequency.

Parameters:
- STAGES, 2, number of synchronizer flops on monitored_clock (minimum 2).
- WINDOW_CYCLES, 1024, measurement window length in reference cycles (minimum 4).
- COUNT_WIDTH, $clog2(WINDOW_CYCLES/2+1), width of the edge count; derived, not overridden.

Ports:
- clock  input  1  reference clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- monitored_clock  input  1  asynchronous clock under measurement, treated as data.
- enable  input  1  measurement enable; low holds the meter idle.
- lower_threshold  input  COUNT_WIDTH  minimum acceptable edges per window.
- upper_threshold  input  COUNT_WIDTH  maximum acceptable edges per window.
- measurement  output  COUNT_WIDTH  rising edges counted in the last completed window.
- measurement_valid  output  1  one-cycle pulse when measurement and the flags update.
- clock_stopped  output  1  last completed window counted zero edges.
- frequency_low  output  1  last measurement < lower_threshold.
- frequency_high  output  1  last measurement > upper_threshold.

Behaviour:
- Reset (synchronous, active-high): synchronizer chain, previous-level register, window counter and edge counter go to 0; measurement = 0; measurement_valid = 0; clock_stopped = 0; frequency_low = 0; frequency_high = 0.
- Synchronizer: monitored_clock passes through STAGES flops to give synced_level.
  - A previous-level register holds last cycle's synced_level.
  - edge = synced_level & ~previous_level.
  - Latency from a monitored rising edge to the edge counter increment: STAGES+1 reference cycles.
- False-edge suppression: while enable = 0, and in the first cycle after reset, the previous-level register loads synced_level and no edge is reported. Enabling the meter never produces a spurious edge.
- Window counter: counts 0 to WINDOW_CYCLES-1 while enable = 1, then wraps to 0. The first window starts in the first cycle enable is sampled high.
- Edge counter: increments on edge. It saturates at 2^COUNT_WIDTH-1 and never wraps.
- Window close (window counter = WINDOW_CYCLES-1 and enable = 1):
  - On the next edge, measurement <= edge_count + edge. An edge in the closing cycle belongs to the closing window.
  - measurement_valid = 1 for exactly one cycle.
  - clock_stopped, frequency_low and frequency_high update from the same value, in the same cycle as measurement.
  - The edge counter restarts at 0.
- Threshold compares:
  - Unsigned.
  - Thresholds are sampled only in the closing cycle; mid-window threshold changes take effect at the next close.
  - lower_threshold > upper_threshold is legal: both frequency flags may assert together.
- Flag independence: clock_stopped is independent of thresholds. With lower_threshold = 0, frequency_low never asserts.
- Enable deassertion mid-window: window and edge counters clear to 0 on the next edge. The partial window is discarded: no valid pulse, outputs hold their last values.
- Reset mid-window: same as power-on reset; all outputs clear.
- Monitored clock stuck high or stuck low: no edges, so measurement = 0 and clock_stopped = 1 at the next close.
- Monitored clock at exactly half the reference frequency: the bound is WINDOW_CYCLES/2 edges, which COUNT_WIDTH covers. Above that rate the result is undefined (aliasing) and is not checked.

Decomposition:
- No shared package needed. COUNT_WIDTH is a derived localparam-style parameter.
- One sub-module: reuse the codebase's existing `synchronizer` (parameter STAGES) for monitored_clock.
- Edge detection, window counter, edge counter and compare logic stay in clock_frequency_meter.

Test Plan:
- Reference period 10 ns, monitored period 31.4159 ns, WINDOW_CYCLES = 1024, enable = 1 → every valid pulse shows measurement within 326 ±1; pulses are exactly 1024 cycles apart; clock_stopped = 0.
- Monitored clock held at 0 for two windows → measurement = 0, clock_stopped = 1 from the first full stopped window. Restart the clock → clock_stopped returns to 0 at the first full running window.
- lower_threshold = 300, upper_threshold = 350: monitored period 40 ns (about 256 edges) → frequency_low = 1; 25 ns (about 410 edges) → frequency_high = 1; 31.4 ns → both 0.
- Monitored clock = reference/2 (period 20 ns) → measurement = 512 ±1, no saturation or wrap in the 10-bit count.
- Deassert enable at window cycle 500 for 50 cycles, then reassert → no valid pulse for the aborted window. The next pulse arrives 1024 cycles after re-enable with a correct count.
- Assert reset for one cycle mid-window after a valid measurement → next cycle all outputs = 0. The first new pulse arrives 1024 cycles after reset release, with no spurious edge counted.
